instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the flintRV core. It issues word-aligned reads to instruction memory starting at a reset PC and byte-swaps returned words when required. Fetched instructions are buffered with their PCs in a small in-order queue and presented to decode (`dec_instr` feeds the decoder and ImmGen directly). Branch/jump redirects flush the queue and discard in-flight responses.

## Interface
- `DEPTH`, 4: queue entries and max in-flight requests; power of 2, ≥ 2
- `RESET_PC`, 32'h0000_0000: first fetch address after reset
- `SWAP_ENDIAN`, 0: 1 = byte-swap every response word before enqueue ({b0,b1,b2,b3})

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `imem_req_valid`  out  1  read request
- `imem_req_addr`  out  32  word address, bits[1:0] always 0
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_rsp_valid`  in  1  read data valid; responses in request order, latency ≥ 1
- `imem_rsp_data`  in  32  read data
- `redirect_valid`  in  1  control-flow redirect
- `redirect_pc`  in  32  redirect target; bits[1:0] ignored (treated as 0)
- `dec_valid`  out  1  queue head valid
- `dec_instr`  out  32  head instruction
- `dec_pc`  out  32  head PC
- `dec_ready`  in  1  decode consumes head

## Operation
- State:
  - `fetch_pc` (next request address)
  - `rsp_pc` (PC of next kept response)
  - queue (`DEPTH` × {instr, pc}, rd/wr pointers, `count` 0..DEPTH)
  - `outst` (requests issued, response not yet returned, 0..DEPTH)
  - `drop` (in-flight responses to discard, ≤ `outst`)
- Request:
  - `imem_req_valid = !rst && !redirect_valid && (count + outst < DEPTH)`.
  - `imem_req_addr = fetch_pc`.
  - Memory samples requests per cycle; a deasserted valid withdraws the request with no obligation.
- Issue (`valid && ready`): `fetch_pc += 4` (wraps mod 2^32); `outst += 1`.
- Response (`imem_rsp_valid`): `outst -= 1`.
  - If `drop > 0`: discard, `drop -= 1`.
  - Otherwise: enqueue {data (swapped if `SWAP_ENDIAN`), `rsp_pc`}, then `rsp_pc += 4`.
  - Response never arrives when the queue is full, because of the credit rule.
- Dequeue: `dec_valid && dec_ready` pops the head.
- Redirect (takes priority over everything except `rst`):
  - Next cycle: queue empty, `fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}`.
  - `outst = drop = outst_cur − imem_rsp_valid`.
  - A response arriving in the redirect cycle is discarded.
  - A dequeue in the redirect cycle has no effect on the flushed queue.
- Simultaneous enqueue and dequeue: `count` unchanged; both pointers advance; full or empty queue handled correctly.
- Pointer wrap: modulo `DEPTH`.

## Timing
- Reset (cycle `rst` sampled high):
  - Next cycle: `fetch_pc = RESET_PC`, `rsp_pc = RESET_PC`, `count = outst = drop = 0`, all storage cleared to 0.
  - Outputs: `dec_valid = 0`, `dec_instr = 0`, `dec_pc = 0`, `imem_req_valid = 0` while `rst` high.
- First request: `imem_req_valid = 1` with `addr = RESET_PC` in the first cycle `rst` is low.
- Reset mid-operation: the same clear applies. Responses to pre-reset requests are not dropped; the memory must be reset together with this block.
- Response to decode: response in cycle N gives `dec_valid = 1` with that entry at the head in cycle N+1, if the queue was empty.
- Redirect in cycle N:
  - `dec_valid = 0` in N+1.
  - First request to the target in N+1, if credit is available.
- Queue outputs (`dec_*`) come from registered storage and the read pointer only; they have no combinational path from `imem_rsp_*` or `redirect_*`.
- `dec_instr`/`dec_pc` hold steady while `dec_valid && !dec_ready`.

## Test plan
- Sequential fetch: `RESET_PC=0x100`, 1-cycle memory, `dec_ready=1` → addrs 0x100, 0x104, 0x108… Decode sees matching instr/pc pairs in order, with no gaps after warm-up.
- Backpressure: `dec_ready=0`, `DEPTH=4`, 2-cycle memory → exactly 4 requests issued, `imem_req_valid` stays 0. Raising `dec_ready` drains 4 entries, then fetch resumes at 0x110.
- Redirect with 3 in flight: 4-cycle memory, redirect to 0x2002 → next addr 0x2000. The 3 stale responses are discarded; the first `dec_pc` shown is 0x2000.
- Redirect coinciding with a response and a dequeue → neither the stale response nor the popped entry appears. `outst`/`drop` go to the pre-redirect in-flight count minus 1.
- Endianness: `SWAP_ENDIAN=1`, response 0x9302_A000 → `dec_instr = 0x00A0_0293` (`addi x5,x0,10`).
- Reset mid-stream with 2 entries queued → `dec_valid=0` next cycle; refetch starts at `RESET_PC`. PC wrap: fetch from 0xFFFF_FFFC → next addr 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads from RESET_PC onward, queues responses with
// their PCs for decode, and flushes on control-flow redirects.
module instr_fetch #(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          SWAP_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [31:0] fix_endian(input logic [31:0] w);
    return SWAP_ENDIAN ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;

  logic [CW:0]   credit_used;
  logic          issue;
  logic          keep;
  logic          drop_now;
  logic          pop;
  logic          unused_pc_bits;

  // Queue slots and in-flight requests share one credit pool, so a response always has room.
  assign credit_used    = {1'b0, count} + {1'b0, outst};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign issue          = imem_req_valid && imem_req_ready;
  assign drop_now       = imem_rsp_valid && (drop != '0);
  assign keep           = imem_rsp_valid && (drop == '0);
  assign pop            = dec_valid && dec_ready;
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign dec_valid = !rst && (count != '0);
  assign dec_instr = rst ? 32'h0 : instr_q[rd_ptr];
  assign dec_pc    = rst ? 32'h0 : pc_q[rd_ptr];

  // Stage p0: control state (PCs, pointers, credit counters)
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rsp_pc   <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // Everything still in flight after this cycle belongs to the old path.
      outst    <= outst - CW'(imem_rsp_valid);
      drop     <= outst - CW'(imem_rsp_valid);
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      outst <= outst + CW'(issue) - CW'(imem_rsp_valid);
      if (drop_now) drop <= drop - CW'(1);
      if (keep) begin
        wr_ptr <= wr_ptr + PW'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(keep) - CW'(pop);
    end
  end

  // Stage p0: queue storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'h0;
        pc_q[i]    <= 32'h0;
      end
    end else if (!redirect_valid && keep) begin
      instr_q[wr_ptr] <= fix_endian(imem_rsp_data);
      pc_q[wr_ptr]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table-driven endian/wrap vectors on one instance, and directed plus
// randomized traffic on another, checked against an epoch-tagged queue model.
module tb_instr_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, dec_valid, dec_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, dec_instr, dec_pc;

  logic        s_rst, s_req_valid, s_req_ready, s_rsp_valid, s_dec_valid;
  logic [31:0] s_req_addr, s_rsp_data, s_dec_instr, s_dec_pc;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC), .SWAP_ENDIAN(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  instr_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .SWAP_ENDIAN(1'b1)) u_sw (
    .clk(clk), .rst(s_rst),
    .imem_req_valid(s_req_valid), .imem_req_addr(s_req_addr), .imem_req_ready(s_req_ready),
    .imem_rsp_valid(s_rsp_valid), .imem_rsp_data(s_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .dec_valid(s_dec_valid), .dec_instr(s_dec_instr), .dec_pc(s_dec_pc), .dec_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int ep; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] rsp; logic [31:0] exp_instr; logic [31:0] exp_pc; } vec_t;

  req_t        pend[$];
  ent_t        q[$];
  logic [31:0] m_fetch;
  int          epoch, cyc, lat, nreq;
  int          n_chk, n_pass;
  bit          arm_first;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // One clock of the main instance: drive, compare against the model, then advance the model.
  task automatic cyc_m(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy, input bit drdy);
    bit   rsp_now, exp_req;
    req_t re;
    int   outs;
    @(negedge clk);
    rst = r; redirect_valid = rd; redirect_pc = rpc; imem_req_ready = rdy; dec_ready = drdy;
    rsp_now = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    re = '{addr: 32'h0, due: 0, ep: -1};
    if (!r && pend.size() > 0 && pend[0].due <= cyc) begin
      re = pend.pop_front();
      rsp_now = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(re.addr);
    end
    #1;
    if (r) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_dec_valid", 32'(dec_valid), 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
      chk("rst_dec_pc", dec_pc, 32'h0);
    end else begin
      outs    = pend.size() + (rsp_now ? 1 : 0);
      exp_req = !rd && (q.size() + outs < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr, m_fetch);
      chk("dec_valid", 32'(dec_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("dec_instr", dec_instr, q[0].instr);
        chk("dec_pc", dec_pc, q[0].pc);
        if (arm_first) begin first_pc = dec_pc; arm_first = 1'b0; end
      end
    end
    if (r) begin
      q.delete(); pend.delete(); m_fetch = RPC; epoch++;
    end else if (rd) begin
      q.delete(); m_fetch = {rpc[31:2], 2'b00}; epoch++;
    end else begin
      if (imem_req_valid && rdy) begin
        pend.push_back('{addr: imem_req_addr, due: cyc + lat + (($urandom_range(0, 3) == 0) ? 1 : 0), ep: epoch});
        m_fetch = m_fetch + 32'd4;
        nreq++;
      end
      if (q.size() != 0 && drdy) void'(q.pop_front());
      if (rsp_now && re.ep == epoch) q.push_back('{instr: mem_word(re.addr), pc: re.addr});
    end
    cyc++;
  endtask

  task automatic run_m(input int n, input bit rdy, input bit drdy);
    for (int i = 0; i < n; i++) cyc_m(1'b0, 1'b0, 32'h0, rdy, drdy);
  endtask

  task automatic reset_m();
    cyc_m(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc_m(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  vec_t tbl[4];

  task automatic swap_phase();
    int  ri, pi, di;
    bit  s_pend, acc;
    ri = 0; pi = 0; di = 0; s_pend = 1'b0;
    @(negedge clk); s_rst = 1'b1;
    @(negedge clk); #1;
    chk("sw_rst_req_valid", 32'(s_req_valid), 32'h0);
    chk("sw_rst_dec_valid", 32'(s_dec_valid), 32'h0);
    for (int c = 0; c < 30 && di < 4; c++) begin
      @(negedge clk);
      s_rst       = 1'b0;
      s_req_ready = (ri < 4);
      s_rsp_valid = s_pend;
      s_rsp_data  = (s_pend && pi < 4) ? tbl[pi].rsp : 32'h0;
      #1;
      acc = s_req_valid && s_req_ready;
      if (acc) chk("sw_req_addr", s_req_addr, tbl[ri].exp_pc);
      if (s_dec_valid && di < 4) begin
        chk("sw_dec_instr", s_dec_instr, tbl[di].exp_instr);
        chk("sw_dec_pc", s_dec_pc, tbl[di].exp_pc);
        di++;
      end
      if (s_pend) pi++;
      s_pend = acc;
      if (acc) ri++;
    end
    chk("sw_entries_seen", 32'(di), 32'd4);
    @(negedge clk); s_rsp_valid = 1'b0; s_req_ready = 1'b0; s_rst = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; epoch = 0; lat = 1; nreq = 0;
    m_fetch = RPC; arm_first = 1'b0; first_pc = 32'hDEAD_BEEF;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    s_rst = 1'b1; s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_data = 32'h0;

    tbl[0] = '{rsp: 32'h9302_A000, exp_instr: 32'h00A0_0293, exp_pc: 32'hFFFF_FFF8};
    tbl[1] = '{rsp: 32'h1122_3344, exp_instr: 32'h4433_2211, exp_pc: 32'hFFFF_FFFC};
    tbl[2] = '{rsp: 32'hDEAD_BEEF, exp_instr: 32'hEFBE_ADDE, exp_pc: 32'h0000_0000};
    tbl[3] = '{rsp: 32'h0000_00FF, exp_instr: 32'hFF00_0000, exp_pc: 32'h0000_0004};

    swap_phase();

    // Sequential fetch, 1-cycle memory, decode always ready
    reset_m(); lat = 1;
    run_m(20, 1'b1, 1'b1);

    // Backpressure: exactly DEPTH requests, then drain and resume at 0x110
    reset_m(); lat = 2; nreq = 0;
    run_m(12, 1'b1, 1'b0);
    chk("bp_nreq", 32'(nreq), 32'(DEPTH));
    run_m(12, 1'b1, 1'b1);

    // Redirect with three requests in flight on a 4-cycle memory
    reset_m(); lat = 4;
    run_m(3, 1'b1, 1'b1);
    cyc_m(1'b0, 1'b1, 32'h0000_2002, 1'b1, 1'b1);
    arm_first = 1'b1; first_pc = 32'hDEAD_BEEF;
    run_m(16, 1'b1, 1'b1);
    chk("redir_first_pc", first_pc, 32'h0000_2000);

    // Redirect coinciding with a response and a dequeue
    reset_m(); lat = 1;
    run_m(6, 1'b1, 1'b1);
    cyc_m(1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    run_m(8, 1'b1, 1'b1);

    // Reset mid-stream with two entries queued, then wrap from 0xFFFF_FFFC
    reset_m(); lat = 1;
    run_m(3, 1'b1, 1'b0);
    cyc_m(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run_m(6, 1'b1, 1'b1);
    cyc_m(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    run_m(8, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bit r, rd;
      logic [31:0] rpc;
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      r   = ($urandom_range(0, 299) == 0);
      rd  = !r && ($urandom_range(0, 39) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom;
      cyc_m(r, rd, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
